// File: rtl/stopwatch_core.sv
// MM:SS stopwatch core: BCD minutes/seconds with run/hold toggle and adjust mode.
// Optional digit-blink request enabled by defining STOPWATCH_BLINK_EN.
module stopwatch_core (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clk_1,
    input  logic       clk_2,
    input  logic       clk_b,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic [3:0] blank
);

    localparam int unsigned DW = 4;
    localparam int unsigned FW = 2 * DW;

    logic          clk_1_d, clk_2_d, pause_d;
    logic          tick1_c, tick2_c, pause_edge_c;
    logic          sec_max_c, inc_sec_c, inc_min_c;
    logic [FW-1:0] sec_nxt_c, min_nxt_c;

    // Two-digit BCD increment that wraps 59 -> 00.
    function automatic logic [FW-1:0] bcd59_inc(input logic [FW-1:0] v);
        logic [DW-1:0] tens, ones;
        tens = v[FW-1:DW];
        ones = v[DW-1:0];
        if (ones >= DW'(9)) begin
            ones = '0;
            tens = (tens >= DW'(5)) ? '0 : DW'(tens + DW'(1));
        end else begin
            ones = DW'(ones + DW'(1));
        end
        return {tens, ones};
    endfunction

    // Edge detection and increment decisions use the pre-toggle running value.
    always_comb begin
        tick1_c      = clk_1 & ~clk_1_d;
        tick2_c      = clk_2 & ~clk_2_d;
        pause_edge_c = pause & ~pause_d;
        sec_max_c    = ({sec_tens, sec_ones} == FW'(8'h59));
        inc_sec_c    = running & (adj ? (tick2_c & sel)  : tick1_c);
        inc_min_c    = running & (adj ? (tick2_c & ~sel) : (tick1_c & sec_max_c));
        sec_nxt_c    = bcd59_inc({sec_tens, sec_ones});
        min_nxt_c    = bcd59_inc({min_tens, min_ones});
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            clk_1_d  <= 1'b0;
            clk_2_d  <= 1'b0;
            pause_d  <= 1'b0;
            running  <= 1'b1;
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
        end else begin
            clk_1_d <= clk_1;
            clk_2_d <= clk_2;
            pause_d <= pause;
            if (pause_edge_c) begin
                running <= ~running;
            end
            if (inc_sec_c) begin
                {sec_tens, sec_ones} <= sec_nxt_c;
            end
            if (inc_min_c) begin
                {min_tens, min_ones} <= min_nxt_c;
            end
        end
    end

`ifdef STOPWATCH_BLINK_EN
    // Blank the digits of the field being adjusted during the high phase of clk_b.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            blank <= '0;
        end else if (adj && clk_b) begin
            blank <= sel ? 4'b0011 : 4'b1100;
        end else begin
            blank <= '0;
        end
    end
`else
    logic unused_clk_b;
    assign unused_clk_b = clk_b;
    assign blank        = '0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core; inputs change on negedge, outputs sampled away from posedge.
module tb_stopwatch_core;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       clk_1 = 1'b0, clk_2 = 1'b0, clk_b = 1'b0;
    logic       pause = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic [3:0] blank;
    logic [15:0] digits;

    int n_cmp = 0;
    int n_err = 0;

`ifdef STOPWATCH_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk_in = ~clk_in;

    stopwatch_core dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .clk_1    (clk_1),
        .clk_2    (clk_2),
        .clk_b    (clk_b),
        .pause    (pause),
        .adj      (adj),
        .sel      (sel),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .blank    (blank)
    );

    task automatic do_reset();
        @(negedge clk_in) rst = 1'b1;
        @(negedge clk_in) rst = 1'b0;
    endtask

    task automatic pulse1(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in) clk_1 = 1'b1;
            @(negedge clk_in) clk_1 = 1'b0;
        end
    endtask

    task automatic pulse2(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in) clk_2 = 1'b1;
            @(negedge clk_in) clk_2 = 1'b0;
        end
    endtask

    task automatic pulse_pause();
        @(negedge clk_in) pause = 1'b1;
        @(negedge clk_in) pause = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (digits !== 16'h0000) begin n_err++; $display("FAIL reset_digits got %h want 0000", digits); end
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL reset_running got %b want 1", running); end
        n_cmp++; if (blank !== 4'b0000) begin n_err++; $display("FAIL reset_blank got %b want 0000", blank); end
    endtask

    task automatic test_count();
        do_reset();
        // First tick must land at the detecting edge, and a held-high input must not retick.
        @(negedge clk_in) clk_1 = 1'b1;
        @(posedge clk_in) #1;
        n_cmp++; if (digits !== 16'h0001) begin n_err++; $display("FAIL count_first got %h want 0001", digits); end
        @(posedge clk_in) #1;
        n_cmp++; if (digits !== 16'h0001) begin n_err++; $display("FAIL count_level got %h want 0001", digits); end
        @(negedge clk_in) clk_1 = 1'b0;
        pulse1(59);
        n_cmp++; if (digits !== 16'h0100) begin n_err++; $display("FAIL count_60 got %h want 0100", digits); end
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL count_running got %b want 1", running); end
        pulse2(3);
        n_cmp++; if (digits !== 16'h0100) begin n_err++; $display("FAIL count_ignore_clk2 got %h want 0100", digits); end
    endtask

    task automatic test_wrap();
        do_reset();
        pulse1(3599);
        n_cmp++; if (digits !== 16'h5959) begin n_err++; $display("FAIL wrap_preload got %h want 5959", digits); end
        @(negedge clk_in) clk_1 = 1'b1;
        @(posedge clk_in) #1;
        n_cmp++; if (digits !== 16'h0000) begin n_err++; $display("FAIL wrap_5959 got %h want 0000", digits); end
        @(negedge clk_in) clk_1 = 1'b0;
    endtask

    task automatic test_adjust();
        do_reset();
        pulse1(58);
        @(negedge clk_in) begin adj = 1'b1; sel = 1'b1; end
        @(posedge clk_in) #1;
        n_cmp++; if (digits !== 16'h0058) begin n_err++; $display("FAIL adj_mode_change got %h want 0058", digits); end
        pulse2(1);
        n_cmp++; if (digits !== 16'h0059) begin n_err++; $display("FAIL adj_sec_59 got %h want 0059", digits); end
        pulse2(1);
        n_cmp++; if (digits !== 16'h0000) begin n_err++; $display("FAIL adj_sec_wrap got %h want 0000", digits); end
        pulse2(1);
        n_cmp++; if (digits !== 16'h0001) begin n_err++; $display("FAIL adj_sec_01 got %h want 0001", digits); end
        pulse1(2);
        n_cmp++; if (digits !== 16'h0001) begin n_err++; $display("FAIL adj_ignore_clk1 got %h want 0001", digits); end
        @(negedge clk_in) sel = 1'b0;
        pulse2(1);
        n_cmp++; if (digits !== 16'h0101) begin n_err++; $display("FAIL adj_min got %h want 0101", digits); end
        pulse2(58);
        pulse2(1);
        n_cmp++; if (digits !== 16'h0001) begin n_err++; $display("FAIL adj_min_wrap got %h want 0001", digits); end
        @(negedge clk_in) adj = 1'b0;
    endtask

    task automatic test_pause();
        do_reset();
        pulse1(3);
        // Pause edge coincident with a tick: tick still counts, then the hold begins.
        @(negedge clk_in) begin pause = 1'b1; clk_1 = 1'b1; end
        @(posedge clk_in) #1;
        n_cmp++; if (digits !== 16'h0004) begin n_err++; $display("FAIL pause_coinc_digits got %h want 0004", digits); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL pause_coinc_running got %b want 0", running); end
        @(negedge clk_in) begin pause = 1'b0; clk_1 = 1'b0; end
        pulse1(5);
        n_cmp++; if (digits !== 16'h0004) begin n_err++; $display("FAIL pause_hold got %h want 0004", digits); end
        @(negedge clk_in) begin adj = 1'b1; sel = 1'b1; end
        pulse2(2);
        n_cmp++; if (digits !== 16'h0004) begin n_err++; $display("FAIL pause_hold_adj got %h want 0004", digits); end
        @(negedge clk_in) adj = 1'b0;
        @(negedge clk_in) begin pause = 1'b1; clk_1 = 1'b1; end
        @(posedge clk_in) #1;
        n_cmp++; if (digits !== 16'h0004) begin n_err++; $display("FAIL resume_coinc_digits got %h want 0004", digits); end
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL resume_coinc_running got %b want 1", running); end
        @(negedge clk_in) begin pause = 1'b0; clk_1 = 1'b0; end
        pulse1(1);
        n_cmp++; if (digits !== 16'h0005) begin n_err++; $display("FAIL resume_count got %h want 0005", digits); end
    endtask

    task automatic test_reset_tick();
        do_reset();
        @(negedge clk_in) begin adj = 1'b1; sel = 1'b0; end
        pulse2(12);
        @(negedge clk_in) sel = 1'b1;
        pulse2(34);
        @(negedge clk_in) adj = 1'b0;
        n_cmp++; if (digits !== 16'h1234) begin n_err++; $display("FAIL rt_preload got %h want 1234", digits); end
        pulse_pause();
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL rt_paused got %b want 0", running); end
        @(negedge clk_in) begin rst = 1'b1; clk_1 = 1'b1; end
        @(posedge clk_in) #1;
        n_cmp++; if (digits !== 16'h0000) begin n_err++; $display("FAIL rt_digits got %h want 0000", digits); end
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL rt_running got %b want 1", running); end
        @(negedge clk_in) begin rst = 1'b0; clk_1 = 1'b0; end
        pulse1(1);
        n_cmp++; if (digits !== 16'h0001) begin n_err++; $display("FAIL rt_after got %h want 0001", digits); end
    endtask

    task automatic test_blink();
        logic [3:0] exp;
        do_reset();
        @(negedge clk_in) begin adj = 1'b1; sel = 1'b0; clk_b = 1'b1; end
        #1;
        n_cmp++; if (blank !== 4'b0000) begin n_err++; $display("FAIL blink_latency got %b want 0000", blank); end
        @(posedge clk_in) #1;
        exp = BLINK ? 4'b1100 : 4'b0000;
        n_cmp++; if (blank !== exp) begin n_err++; $display("FAIL blink_min got %b want %b", blank, exp); end
        @(negedge clk_in) clk_b = 1'b0;
        @(posedge clk_in) #1;
        n_cmp++; if (blank !== 4'b0000) begin n_err++; $display("FAIL blink_low got %b want 0000", blank); end
        @(negedge clk_in) begin sel = 1'b1; clk_b = 1'b1; end
        @(posedge clk_in) #1;
        exp = BLINK ? 4'b0011 : 4'b0000;
        n_cmp++; if (blank !== exp) begin n_err++; $display("FAIL blink_sec got %b want %b", blank, exp); end
        @(negedge clk_in) adj = 1'b0;
        @(posedge clk_in) #1;
        n_cmp++; if (blank !== 4'b0000) begin n_err++; $display("FAIL blink_count_mode got %b want 0000", blank); end
        n_cmp++; if (digits !== 16'h0000) begin n_err++; $display("FAIL blink_digits got %h want 0000", digits); end
        @(negedge clk_in) clk_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_adjust();
        test_pause();
        test_reset_tick();
        test_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk_in.
REQ-002 clk_in  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 clk_1  input  1  1 Hz square wave from the clock-divider stage, same clk_in domain.
REQ-005 clk_2  input  1  2 Hz square wave from the clock-divider stage, same clk_in domain.
REQ-006 clk_b  input  1  blink square wave from the clock-divider stage; used only when STOPWATCH_BLINK_EN is defined.
REQ-007 pause  input  1  debounced level; each rising edge toggles run/hold.
REQ-008 adj  input  1  1 = adjust mode, 0 = count mode.
REQ-009 sel  input  1  adjust target: 0 = minutes, 1 = seconds.
REQ-010 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits, registered.
REQ-011 running  output  1  1 = counting enabled, registered.
REQ-012 blank  output  4  per-digit blank request, [3]=min_tens ... [0]=sec_ones.

Function
REQ-013 The block SHALL hold one delayed copy each of clk_1, clk_2 and pause, and SHALL define a tick as input=1 while its delayed copy=0.
REQ-014 tick1, tick2 and the pause edge SHALL each be asserted for exactly one clk_in cycle per rising edge of the input.
REQ-015 A rising pause edge SHALL toggle running at the same clk_in edge at which it is detected.
REQ-016 When running=1 and adj=0, tick1 SHALL increment seconds at that same edge, with zero added latency.
REQ-017 Seconds SHALL count 00..59; at 59 a tick SHALL set seconds to 00 and increment minutes.
REQ-018 Minutes SHALL count 00..59; at 59:59 a tick1 SHALL produce 00:00.
REQ-019 Each field SHALL be stored as two BCD digits; ones SHALL wrap 9->0 with a carry into tens; no digit SHALL ever hold a value above 9, and no tens digit a value above 5.
REQ-020 When running=1 and adj=1, tick2 SHALL increment only the field selected by sel, wrapping 59->00 with no carry into the other field.
REQ-021 When adj=0, tick2 SHALL be ignored; when adj=1, tick1 SHALL be ignored.
REQ-022 When running=0, all ticks SHALL be ignored and the digits SHALL hold.
REQ-023 If a pause edge and a tick occur in the same cycle, the tick SHALL be evaluated against the pre-toggle running value.
REQ-024 A change of adj or sel SHALL take effect in the same cycle it is sampled; no digit SHALL be altered by the mode change itself.

Reset
REQ-025 When rst=1 at a clock edge, digits SHALL be 0, running SHALL be 1, blank SHALL be 4'b0000, and the delayed copies SHALL be 0.
REQ-026 rst SHALL override every tick and pause edge in the same cycle; a reset mid-count SHALL discard any pending increment.

Configuration
REQ-027 Macro STOPWATCH_BLINK_EN defined: while adj=1 and clk_b=1, blank SHALL be 4'b1100 when sel=0 and 4'b0011 when sel=1; otherwise blank SHALL be 0; blank SHALL be registered with one cycle of latency.
REQ-028 Macro STOPWATCH_BLINK_EN undefined: blank SHALL be constant 4'b0000 and clk_b SHALL be ignored; the port SHALL remain present.
REQ-029 Digit values SHALL be identical whether or not the macro is defined.

Verification
REQ-030 Reset, then adj=0 and 60 clk_1 rising edges -> digits 01:00; running=1.
REQ-031 Preload 59:59 by counting, then one clk_1 edge -> 00:00 at the detecting edge.
REQ-032 adj=1, sel=1, seconds=58, three clk_2 edges -> seconds 59, 00, 01; minutes unchanged; clk_1 edges cause no change.
REQ-033 Pause edge coincident with clk_1 edge while running -> count increments once, running=0, then 5 clk_1 edges -> no change.
REQ-034 rst asserted in the same cycle as a tick at 12:34 -> 00:00, running=1.
REQ-035 With STOPWATCH_BLINK_EN defined, adj=1, sel=0, clk_b high -> blank=4'b1100 one cycle later; clk_b low -> 4'b0000; macro undefined -> always 4'b0000.
